// File: rtl/cpu6502_status_register_pkg.sv
// rtl/cpu6502_status_register_pkg.sv - flag bit positions, flagOp encodings and P packing helper
package cpu6502_status_register_pkg;

  // Bit positions of each flag inside the P byte.
  localparam int C_BIT_IN_P = 0;
  localparam int Z_BIT_IN_P = 1;
  localparam int I_BIT_IN_P = 2;
  localparam int D_BIT_IN_P = 3;
  localparam int B_BIT_IN_P = 4;
  localparam int U_BIT_IN_P = 5;
  localparam int V_BIT_IN_P = 6;
  localparam int N_BIT_IN_P = 7;

  // Microcode single-flag operations.
  typedef enum logic [2:0] {
    FLAG_OP_CLC      = 3'd0,
    FLAG_OP_SEC      = 3'd1,
    FLAG_OP_CLI      = 3'd2,
    FLAG_OP_SEI      = 3'd3,
    FLAG_OP_CLD      = 3'd4,
    FLAG_OP_SED      = 3'd5,
    FLAG_OP_CLV      = 3'd6,
    FLAG_OP_RESERVED = 3'd7
  } flagOp_e;

  // The six flags that are actually stored.
  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0, i: 1'b1, z: 1'b0, c: 1'b0};

  // Assemble the architectural P byte; bit5 always reads 1, bit4 is whatever B is being pushed.
  function automatic logic [7:0] packP(input flags_t f, input logic brk);
    logic [7:0] p;
    p             = 8'h00;
    p[N_BIT_IN_P] = f.n;
    p[V_BIT_IN_P] = f.v;
    p[U_BIT_IN_P] = 1'b1;
    p[B_BIT_IN_P] = brk;
    p[D_BIT_IN_P] = f.d;
    p[I_BIT_IN_P] = f.i;
    p[Z_BIT_IN_P] = f.z;
    p[C_BIT_IN_P] = f.c;
    return p;
  endfunction

  // Unpack the stored flags from a byte pulled off the stack; bits 5 and 4 are dropped.
  function automatic flags_t unpackP(input logic [7:0] p);
    flags_t f;
    f.n = p[N_BIT_IN_P];
    f.v = p[V_BIT_IN_P];
    f.d = p[D_BIT_IN_P];
    f.i = p[I_BIT_IN_P];
    f.z = p[Z_BIT_IN_P];
    f.c = p[C_BIT_IN_P];
    return f;
  endfunction

endpackage

// File: rtl/cpu6502_status_register_if.sv
// rtl/cpu6502_status_register_if.sv - microcode/ALU side bundle for the status register
interface cpu6502_status_register_if;

  logic       ce;
  logic       aluCarry;
  logic       aluZero;
  logic       aluNegative;
  logic       aluOverflow;
  logic       updateNZ;
  logic       updateC;
  logic       updateV;
  logic       bitOp;
  logic       pLoad;
  logic [7:0] dataIn;
  logic       flagOpEn;
  logic [2:0] flagOp;
  logic       interruptEntry;
  logic       pushBrk;
  logic       pollStrobe;
  logic       soN;
  logic [7:0] pOut;
  logic       carry;
  logic       overflow;
  logic       decimal;
  logic       irqMask;

  // Sequencer/ALU side: drives controls, consumes flags.
  modport master (
    output ce, aluCarry, aluZero, aluNegative, aluOverflow,
    output updateNZ, updateC, updateV, bitOp, pLoad, dataIn,
    output flagOpEn, flagOp, interruptEntry, pushBrk, pollStrobe, soN,
    input  pOut, carry, overflow, decimal, irqMask
  );

  // Status register side.
  modport slave (
    input  ce, aluCarry, aluZero, aluNegative, aluOverflow,
    input  updateNZ, updateC, updateV, bitOp, pLoad, dataIn,
    input  flagOpEn, flagOp, interruptEntry, pushBrk, pollStrobe, soN,
    output pOut, carry, overflow, decimal, irqMask
  );

endinterface

// File: rtl/cpu6502_status_register_so_edge_detect.sv
// rtl/cpu6502_status_register_so_edge_detect.sv - SO pin synchroniser, falling-edge detect and pending latch
module cpu6502_so_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic soN,
  output logic soSetV
);

  logic [SYNC_STAGES-1:0] soSync;
  logic                   soFell;
  logic                   soPending;

  // The edge is taken between the two oldest stages so the pin lands in V SYNC_STAGES+1 clks later.
  assign soFell = soSync[SYNC_STAGES-1] & ~soSync[SYNC_STAGES-2];

  // Pending is only consumed on a ce cycle; soSetV is that consumption.
  assign soSetV = ce & soPending;

  // Synchroniser runs every clk; idle level of the pin is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      soSync <= '1;
    end else begin
      soSync <= {soSync[SYNC_STAGES-2:0], soN};
    end
  end

  // A new edge always wins over consumption so an edge landing on the applying cycle is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      soPending <= 1'b0;
    end else if (soFell) begin
      soPending <= 1'b1;
    end else if (ce) begin
      soPending <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu6502_status_register.sv
// rtl/cpu6502_status_register.sv - 6502 processor status register P
module cpu6502_status_register
  import cpu6502_status_register_pkg::*;
#(
  parameter bit CMOS           = 1'b0,
  parameter int SO_SYNC_STAGES = 2
) (
  input logic                          clk,
  input logic                          reset,
  cpu6502_status_register_if.slave     bus
);

  flags_t  flags;
  flags_t  flagsNext;
  logic    irqMaskReg;
  logic    soSetV;
  flagOp_e op;
  logic    opValid;

  assign op      = flagOp_e'(bus.flagOp);
  assign opValid = bus.flagOpEn;

  cpu6502_so_edge_detect #(
    .SYNC_STAGES(SO_SYNC_STAGES)
  ) soEdge (
    .clk    (clk),
    .reset  (reset),
    .ce     (bus.ce),
    .soN    (bus.soN),
    .soSetV (soSetV)
  );

  // Per-flag priority: pLoad, interrupt entry, flag op, ALU/BIT; untouched flags fall through.
  always_comb begin
    flags_t loaded;
    loaded    = unpackP(bus.dataIn);
    flagsNext = flags;

    // Carry
    if (bus.pLoad) begin
      flagsNext.c = loaded.c;
    end else if (opValid && op == FLAG_OP_CLC) begin
      flagsNext.c = 1'b0;
    end else if (opValid && op == FLAG_OP_SEC) begin
      flagsNext.c = 1'b1;
    end else if (bus.updateC) begin
      flagsNext.c = bus.aluCarry;
    end

    // Zero
    if (bus.pLoad) begin
      flagsNext.z = loaded.z;
    end else if (bus.updateNZ) begin
      flagsNext.z = bus.aluZero;
    end

    // Interrupt disable
    if (bus.pLoad) begin
      flagsNext.i = loaded.i;
    end else if (bus.interruptEntry) begin
      flagsNext.i = 1'b1;
    end else if (opValid && op == FLAG_OP_CLI) begin
      flagsNext.i = 1'b0;
    end else if (opValid && op == FLAG_OP_SEI) begin
      flagsNext.i = 1'b1;
    end

    // Decimal: only the 65C02 clears it when taking an interrupt
    if (bus.pLoad) begin
      flagsNext.d = loaded.d;
    end else if (bus.interruptEntry && CMOS) begin
      flagsNext.d = 1'b0;
    end else if (opValid && op == FLAG_OP_CLD) begin
      flagsNext.d = 1'b0;
    end else if (opValid && op == FLAG_OP_SED) begin
      flagsNext.d = 1'b1;
    end

    // Overflow: the SO pin beats everything, including a stack load
    if (soSetV) begin
      flagsNext.v = 1'b1;
    end else if (bus.pLoad) begin
      flagsNext.v = loaded.v;
    end else if (opValid && op == FLAG_OP_CLV) begin
      flagsNext.v = 1'b0;
    end else if (bus.bitOp) begin
      flagsNext.v = bus.dataIn[V_BIT_IN_P];
    end else if (bus.updateV) begin
      flagsNext.v = bus.aluOverflow;
    end

    // Negative: BIT takes N from memory, overriding the ALU
    if (bus.pLoad) begin
      flagsNext.n = loaded.n;
    end else if (bus.bitOp) begin
      flagsNext.n = bus.dataIn[N_BIT_IN_P];
    end else if (bus.updateNZ) begin
      flagsNext.n = bus.aluNegative;
    end
  end

  // Architectural flag storage, advanced only on CPU cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= FLAGS_RESET;
    end else if (bus.ce) begin
      flags <= flagsNext;
    end
  end

  // Poll samples I before this cycle's update, giving CLI/SEI/PLP their one-instruction delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqMaskReg <= 1'b1;
    end else if (bus.ce && bus.pollStrobe) begin
      irqMaskReg <= flags.i;
    end
  end

  assign bus.pOut     = packP(flags, bus.pushBrk);
  assign bus.carry    = flags.c;
  assign bus.overflow = flags.v;
  assign bus.decimal  = flags.d;
  assign bus.irqMask  = irqMaskReg;

endmodule
